step5_normalize_pack: RTL
=========================

STEP5_NORMALIZE_PACK -- requirements
Module: step5_normalize_pack

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width; all values below assume the default.
REQ-002 Parameter MANT_W, default 23, stored fraction width; all values below assume the default.
REQ-003 clock  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream status/magnitude word valid.
REQ-006 in_ready  output  1  block can accept a word.
REQ-007 in_sign  input  1  registered result sign from the adder status stage.
REQ-008 in_ov_sign  input  1  adder magnitude carry-out flag; 1 means in_mant[24] holds a carry.
REQ-009 in_exp  input  8  biased exponent of the unnormalized magnitude.
REQ-010 in_mant  input  25  magnitude: bit 24 carry, bit 23 hidden-bit position, bits 22:0 fraction.
REQ-011 out_valid  output  1  packed result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_result  output  32  packed single-precision word {sign, exp[7:0], frac[22:0]}.
REQ-014 out_flags  output  3  {overflow, underflow, zero}.

Function
REQ-015 The FSM SHALL have three states: IDLE, NORM and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE with reset deasserted; transfer occurs when in_valid and in_ready are both 1.
REQ-017 On transfer, the block SHALL capture sign, exponent (zero-extended to 9 bits), mantissa and ov flag, then enter NORM.
REQ-018 In NORM, mant == 0 SHALL go to DONE with zero = 1; out_result = {in_sign, 31'b0}.
REQ-019 In NORM, mant[24] == 1 SHALL shift mant right by 1 (truncating), increment exp, and go to DONE.
REQ-020 In NORM, mant[23] == 1 or exp == 1 SHALL go to DONE.
REQ-021 In NORM, otherwise, the block SHALL shift mant left by 1, decrement exp, and stay in NORM; at most 23 left shifts per word.
REQ-022 Latency SHALL be 2 + (left-shift count) cycles from the transfer edge to out_valid.
REQ-023 In DONE with exp >= 255, or captured in_exp == 255, the result SHALL be {sign, 8'hFF, 23'b0} with overflow = 1.
REQ-024 In DONE with exp == 1 and mant[23] == 0, the result SHALL be denormal: exponent field 0, frac = mant[22:0], underflow = 1.
REQ-025 A normal result SHALL be {sign, exp[7:0], mant[22:0]} with flags 000; rounding is truncation only.
REQ-026 out_valid SHALL be 1 only in DONE; out_result and out_flags SHALL be held stable while out_valid = 1 and out_ready = 0.
REQ-027 DONE with out_ready = 1 SHALL return to IDLE on the next edge; the next transfer is possible no earlier than one cycle after the handoff (no overlap).
REQ-028 in_ov_sign SHALL be informational only; normalization SHALL key on mant[24]; an in_ov_sign/mant[24] mismatch SHALL NOT change the result.

Reset
REQ-029 While reset = 1: state = IDLE, out_valid = 0, out_result = 0, out_flags = 0, in_ready = 0, and all internal registers cleared.
REQ-030 Reset asserted mid-NORM or mid-DONE SHALL abort the word with no output; after release the block SHALL be in IDLE with in_ready = 1 on the first edge.

Verification
REQ-031 Normal input: sign 0, exp 0x7F, mant 0x0800000 -> out_result 0x3F800000, flags 000, out_valid 2 cycles after transfer.
REQ-032 Carry input: sign 1, ov 1, exp 0x80, mant 0x1800000 -> 0xC0C00000, flags 000, latency 2.
REQ-033 Deep normalize: sign 0, exp 0x7F, mant 0x0000001 -> 0x34000000, latency 25.
REQ-034 Zero and overflow: sign 1, mant 0 -> 0x80000000, flags 001; sign 0, ov 1, exp 0xFE, mant 0x1000000 -> 0x7F800000, flags 100.
REQ-035 Denormal: exp 0x02, mant 0x0100000 -> 0x00200000, flags 010, latency 3.
REQ-036 Backpressure and reset: hold out_ready = 0 for 5 cycles -> result stable and in_ready = 0; pulse reset during NORM -> out_valid never asserts, and in_ready = 1 after release.

Source files
------------

// File: rtl/step5_normalize_pack.sv
// Final stage of the floating-point adder: takes the unnormalized magnitude
// and biased exponent from the status stage, normalizes it one bit per cycle,
// then packs an IEEE-754 single-precision word with overflow/underflow/zero flags.
module step5_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sign,
    input  logic                      in_ov_sign,
    input  logic [EXP_W-1:0]          in_exp,
    input  logic [MANT_W+1:0]         in_mant,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W:0]     out_result,
    output logic [2:0]                out_flags
);

    // One extra exponent bit so a carry-in increment past the all-ones code is visible.
    localparam int XW = EXP_W + 1;
    localparam int CNT_W = $clog2(MANT_W + 1);
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [XW-1:0] EXP_ONE = XW'(1);
    localparam logic [CNT_W-1:0] SHIFT_MAX = CNT_W'(MANT_W);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t             state;
    logic               sign_r;
    logic               ov_r;
    logic               max_in_r;
    logic [XW-1:0]      exp_r;
    logic [MANT_W+1:0]  mant_r;
    logic [CNT_W-1:0]   shift_cnt;
    logic [EXP_W+MANT_W:0] pack_result;
    logic [2:0]         pack_flags;
    logic               unused_ov;

    // The carry flag from the adder is kept for debug visibility only;
    // normalization always trusts the magnitude's own carry bit.
    assign unused_ov = ov_r;

    // Upstream may hand over a word only while we sit idle and out of reset.
    assign in_ready = (state == IDLE) && !reset;

    // Packing decision on the normalized magnitude: zero wins, then overflow
    // (including an incoming all-ones exponent), then denormal, else normal.
    always_comb begin
        pack_result = '0;
        pack_flags  = 3'b000;
        if (mant_r == '0) begin
            pack_result = {sign_r, {(EXP_W+MANT_W){1'b0}}};
            pack_flags  = 3'b001;
        end else if (max_in_r || (exp_r >= EXP_MAX)) begin
            pack_result = {sign_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            pack_flags  = 3'b100;
        end else if ((exp_r <= EXP_ONE) && !mant_r[MANT_W]) begin
            pack_result = {sign_r, {EXP_W{1'b0}}, mant_r[MANT_W-1:0]};
            pack_flags  = 3'b010;
        end else begin
            pack_result = {sign_r, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]};
            pack_flags  = 3'b000;
        end
    end

    // Capture, normalize one step per cycle, then present the packed result until taken.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sign_r     <= 1'b0;
            ov_r       <= 1'b0;
            max_in_r   <= 1'b0;
            exp_r      <= '0;
            mant_r     <= '0;
            shift_cnt  <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_r    <= in_sign;
                        ov_r      <= in_ov_sign;
                        max_in_r  <= (in_exp == {EXP_W{1'b1}});
                        exp_r     <= {1'b0, in_exp};
                        mant_r    <= in_mant;
                        shift_cnt <= '0;
                        state     <= NORM;
                    end
                end
                NORM: begin
                    if (mant_r == '0) begin
                        state <= DONE;
                    end else if (mant_r[MANT_W+1]) begin
                        mant_r <= mant_r >> 1;
                        exp_r  <= exp_r + EXP_ONE;
                        state  <= DONE;
                    end else if (mant_r[MANT_W] || (exp_r <= EXP_ONE) ||
                                 (shift_cnt == SHIFT_MAX)) begin
                        state <= DONE;
                    end else begin
                        mant_r    <= mant_r << 1;
                        exp_r     <= exp_r - EXP_ONE;
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_result <= pack_result;
                        out_flags  <= pack_flags;
                        out_valid  <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
